// File: rtl/vga_frame_scanner.sv
// VGA 640x480@60 scanner reading a 320x240 frame buffer with 2x2 pixel replication.
// Optional build macro: TEST_PATTERN_EN adds a test_mode input that replaces pixel data with vertical bars.
module vga_frame_scanner #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 20,
    parameter int IMG_W      = 320,
    parameter int IMG_H      = 240,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33
) (
    input  logic                  CLOCK_50,
    input  logic                  RESET,
    output logic [ADDR_WIDTH-1:0] fb_addr,
    output logic                  fb_enable,
    output logic                  fb_write,
    input  logic [DATA_WIDTH-1:0] fb_data,
    output logic                  VGA_CLK,
    output logic                  VGA_HS,
    output logic                  VGA_VS,
    output logic                  VGA_BLANK_N,
    output logic [DATA_WIDTH-1:0] VGA_R,
    output logic [DATA_WIDTH-1:0] VGA_G,
    output logic [DATA_WIDTH-1:0] VGA_B,
    output logic                  frame_start
`ifdef TEST_PATTERN_EN
    ,
    input  logic                  test_mode
`endif
);

    // Counters are 10 bits wide so that the test-pattern bars can always use h[9:7].
    localparam logic [9:0] H_VIS    = 10'(2 * IMG_W);
    localparam logic [9:0] V_VIS    = 10'(2 * IMG_H);
    localparam logic [9:0] H_TOTAL  = 10'(2 * IMG_W + H_FP + H_SYNC + H_BP);
    localparam logic [9:0] V_TOTAL  = 10'(2 * IMG_H + V_FP + V_SYNC + V_BP);
    localparam logic [9:0] HS_START = 10'(2 * IMG_W + H_FP);
    localparam logic [9:0] HS_END   = 10'(2 * IMG_W + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_START = 10'(2 * IMG_H + V_FP);
    localparam logic [9:0] VS_END   = 10'(2 * IMG_H + V_FP + V_SYNC - 1);

    logic                  pix_tick_q;
    logic [9:0]            h_cnt_q, h_cnt_d;
    logic [9:0]            v_cnt_q, v_cnt_d;
    logic [ADDR_WIDTH-1:0] fb_addr_q, addr_d;
    logic                  fb_enable_q;
    logic                  hs_q, vs_q, blank_n_q;
    logic [DATA_WIDTH-1:0] pix_q, pix_d;
    logic                  frame_start_q;
    logic                  vis_d, vis_q, hs_d, vs_d;
    logic                  test_en;

`ifdef TEST_PATTERN_EN
    assign test_en = test_mode;
`else
    assign test_en = 1'b0;
`endif

    // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (pix_tick_q) begin
            if (h_cnt_q == H_TOTAL - 10'd1) begin
                h_cnt_d = 10'd0;
                v_cnt_d = (v_cnt_q == V_TOTAL - 10'd1) ? 10'd0 : v_cnt_q + 10'd1;
            end else begin
                h_cnt_d = h_cnt_q + 10'd1;
            end
        end
        vis_d  = (h_cnt_d < H_VIS) && (v_cnt_d < V_VIS);
        addr_d = ADDR_WIDTH'(v_cnt_d >> 1) * ADDR_WIDTH'(IMG_W) + ADDR_WIDTH'(h_cnt_d >> 1);
    end

    // Stage C view: the current counters are the (h,v) whose read was issued one pixel earlier.
    always_comb begin
        vis_q = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
        hs_d  = !((h_cnt_q >= HS_START) && (h_cnt_q <= HS_END));
        vs_d  = !((v_cnt_q >= VS_START) && (v_cnt_q <= VS_END));
        pix_d = '0;
        if (vis_q) begin
            pix_d = test_en ? {h_cnt_q[9:7], {(DATA_WIDTH-3){1'b0}}} : fb_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            pix_tick_q    <= 1'b0;
            h_cnt_q       <= H_TOTAL - 10'd1;
            v_cnt_q       <= V_TOTAL - 10'd1;
            fb_addr_q     <= '0;
            fb_enable_q   <= 1'b0;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            blank_n_q     <= 1'b0;
            pix_q         <= '0;
            frame_start_q <= 1'b0;
        end else begin
            pix_tick_q    <= ~pix_tick_q;
            frame_start_q <= pix_tick_q && (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
            if (pix_tick_q) begin
                h_cnt_q     <= h_cnt_d;
                v_cnt_q     <= v_cnt_d;
                fb_enable_q <= vis_d && !test_en;
                if (vis_d) begin
                    fb_addr_q <= addr_d;
                end
                hs_q      <= hs_d;
                vs_q      <= vs_d;
                blank_n_q <= vis_q;
                pix_q     <= pix_d;
            end
        end
    end

    assign fb_addr     = fb_addr_q;
    assign fb_enable   = fb_enable_q;
    assign fb_write    = 1'b0;
    assign VGA_CLK     = pix_tick_q;
    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;
    assign VGA_BLANK_N = blank_n_q;
    assign VGA_R       = pix_q;
    assign VGA_G       = pix_q;
    assign VGA_B       = pix_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_frame_scanner.sv
// Directed bench for vga_frame_scanner: full-size instance for line-level behaviour,
// a shrunken-geometry instance for frame-level timing and maximum address.
module tb_vga_frame_scanner;

    logic        CLOCK_50;
    logic        rst;
    logic        force_ff;
    int          checks;
    int          errors;
    int          edge_cnt;
    int          wr_bad;

    logic [19:0] fb_addr,   fb_addr_s;
    logic        fb_enable, fb_enable_s;
    logic        fb_write,  fb_write_s;
    logic [7:0]  fb_data,   fb_data_s;
    logic        vclk,      vclk_s;
    logic        hs,        hs_s;
    logic        vs,        vs_s;
    logic        blank_n,   blank_n_s;
    logic [7:0]  r, g, b,   r_s, g_s, b_s;
    logic        fs,        fs_s;
`ifdef TEST_PATTERN_EN
    logic        test_mode;
`endif

    vga_frame_scanner u_dut (
        .CLOCK_50(CLOCK_50), .RESET(rst),
        .fb_addr(fb_addr), .fb_enable(fb_enable), .fb_write(fb_write), .fb_data(fb_data),
        .VGA_CLK(vclk), .VGA_HS(hs), .VGA_VS(vs), .VGA_BLANK_N(blank_n),
        .VGA_R(r), .VGA_G(g), .VGA_B(b), .frame_start(fs)
`ifdef TEST_PATTERN_EN
        , .test_mode(test_mode)
`endif
    );

    // 16x8 visible, 24 ticks per line, 12 lines per frame -> 576 CLOCK_50 per frame.
    vga_frame_scanner #(
        .IMG_W(8), .IMG_H(4), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) u_small (
        .CLOCK_50(CLOCK_50), .RESET(rst),
        .fb_addr(fb_addr_s), .fb_enable(fb_enable_s), .fb_write(fb_write_s), .fb_data(fb_data_s),
        .VGA_CLK(vclk_s), .VGA_HS(hs_s), .VGA_VS(vs_s), .VGA_BLANK_N(blank_n_s),
        .VGA_R(r_s), .VGA_G(g_s), .VGA_B(b_s), .frame_start(fs_s)
`ifdef TEST_PATTERN_EN
        , .test_mode(1'b0)
`endif
    );

    function automatic logic [7:0] rom_val(input logic [19:0] a);
        if (a == 20'd0) return 8'h5A;
        return 8'(a * 20'd13 + 20'd7);
    endfunction

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    // Frame-buffer models: registered read, one cycle latency.
    always @(posedge CLOCK_50) begin
        if (force_ff)       fb_data <= 8'hFF;
        else if (fb_enable) fb_data <= rom_val(fb_addr);
        if (fb_enable_s)    fb_data_s <= rom_val(fb_addr_s);
    end

    always @(posedge CLOCK_50 or posedge rst) begin
        if (rst) edge_cnt <= 0;
        else     edge_cnt <= edge_cnt + 1;
    end

    always @(posedge CLOCK_50) begin
        if (fb_write !== 1'b0 || fb_write_s !== 1'b0) wr_bad <= wr_bad + 1;
    end

    // Edge after reset release at which (h,v) becomes current on an 800-tick line.
    function automatic int stage_a(input int h, input int v, input int total);
        return 2 * (v * total + h + 1);
    endfunction

    task automatic wait_edge(input int e);
        if (edge_cnt > e) begin
            errors++;
            $display("FAIL sched: edge %0d already passed, now %0d", e, edge_cnt);
        end
        while (edge_cnt < e) @(negedge CLOCK_50);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        checks++; if (fb_addr !== 20'd0)  begin errors++; $display("FAIL rst_addr: got %h want 0", fb_addr); end
        checks++; if (fb_enable !== 1'b0) begin errors++; $display("FAIL rst_en: got %b want 0", fb_enable); end
        checks++; if (hs !== 1'b1)        begin errors++; $display("FAIL rst_hs: got %b want 1", hs); end
        checks++; if (vs !== 1'b1)        begin errors++; $display("FAIL rst_vs: got %b want 1", vs); end
        checks++; if (blank_n !== 1'b0)   begin errors++; $display("FAIL rst_blank: got %b want 0", blank_n); end
        checks++; if ({r, g, b} !== 24'h0) begin errors++; $display("FAIL rst_rgb: got %h want 0", {r, g, b}); end
        checks++; if (fs !== 1'b0)        begin errors++; $display("FAIL rst_fs: got %b want 0", fs); end
        checks++; if (vclk !== 1'b0)      begin errors++; $display("FAIL rst_vclk: got %b want 0", vclk); end
        rst = 1'b0;
    endtask

    task automatic test_first_pixel();
        wait_edge(1);
        checks++; if (fb_enable !== 1'b0) begin errors++; $display("FAIL e1_en: got %b want 0", fb_enable); end
        wait_edge(2);
        checks++; if (fb_addr !== 20'd0)  begin errors++; $display("FAIL e2_addr: got %h want 0", fb_addr); end
        checks++; if (fb_enable !== 1'b1) begin errors++; $display("FAIL e2_en: got %b want 1", fb_enable); end
        checks++; if (blank_n !== 1'b0)   begin errors++; $display("FAIL e2_blank: got %b want 0", blank_n); end
        wait_edge(4);
        checks++; if ({r, g, b} !== {3{8'h5A}}) begin errors++; $display("FAIL e4_rgb: got %h want 5a5a5a", {r, g, b}); end
        checks++; if (blank_n !== 1'b1)   begin errors++; $display("FAIL e4_blank: got %b want 1", blank_n); end
        checks++; if (fs !== 1'b1)        begin errors++; $display("FAIL e4_fs: got %b want 1", fs); end
        wait_edge(5);
        checks++; if (fs !== 1'b0)        begin errors++; $display("FAIL e5_fs: got %b want 0", fs); end
    endtask

    task automatic test_scaling();
        wait_edge(stage_a(2, 0, 800));
        checks++; if (fb_addr !== 20'd1) begin errors++; $display("FAIL addr_h2v0: got %0d want 1", fb_addr); end
        wait_edge(stage_a(3, 0, 800));
        checks++; if (fb_addr !== 20'd1) begin errors++; $display("FAIL addr_h3v0: got %0d want 1", fb_addr); end
        checks++; if (r !== rom_val(20'd1)) begin errors++; $display("FAIL pix_h2v0: got %h want %h", r, rom_val(20'd1)); end
        wait_edge(stage_a(2, 1, 800));
        checks++; if (fb_addr !== 20'd1) begin errors++; $display("FAIL addr_h2v1: got %0d want 1", fb_addr); end
        wait_edge(stage_a(3, 1, 800));
        checks++; if (fb_addr !== 20'd1) begin errors++; $display("FAIL addr_h3v1: got %0d want 1", fb_addr); end
        wait_edge(stage_a(0, 2, 800));
        checks++; if (fb_addr !== 20'd320) begin errors++; $display("FAIL addr_h0v2: got %0d want 320", fb_addr); end
    endtask

    task automatic test_small_frame();
        int hs_lo, vs_lo, bl_hi, fs_hi;
        hs_lo = 0; vs_lo = 0; bl_hi = 0; fs_hi = 0;
        wait_edge(4 + 576 * 6 - 1);
        checks++; if (fs_s !== 1'b0) begin errors++; $display("FAIL s_fs_pre: got %b want 0", fs_s); end
        wait_edge(4 + 576 * 6);
        checks++; if (fs_s !== 1'b1) begin errors++; $display("FAIL s_fs_period: got %b want 1", fs_s); end
        wait_edge(stage_a(15, 7, 24) + 576 * 6);
        checks++; if (fb_addr_s !== 20'd31) begin errors++; $display("FAIL s_addr_max: got %0d want 31", fb_addr_s); end
        wait_edge(stage_a(15, 7, 24) + 576 * 6 + 2);
        checks++; if (r_s !== rom_val(20'd31)) begin errors++; $display("FAIL s_pix_max: got %h want %h", r_s, rom_val(20'd31)); end
        wait_edge(3900);
        for (int i = 0; i < 576; i++) begin
            if (hs_s === 1'b0) hs_lo++;
            if (vs_s === 1'b0) vs_lo++;
            if (blank_n_s === 1'b1) bl_hi++;
            if (fs_s === 1'b1) fs_hi++;
            @(negedge CLOCK_50);
        end
        checks++; if (hs_lo !== 72)  begin errors++; $display("FAIL s_hs_count: got %0d want 72", hs_lo); end
        checks++; if (vs_lo !== 96)  begin errors++; $display("FAIL s_vs_count: got %0d want 96", vs_lo); end
        checks++; if (bl_hi !== 256) begin errors++; $display("FAIL s_blank_count: got %0d want 256", bl_hi); end
        checks++; if (fs_hi !== 1)   begin errors++; $display("FAIL s_fs_count: got %0d want 1", fs_hi); end
    endtask

    task automatic test_hsync_edges();
        wait_edge(stage_a(655, 2, 800) + 2);
        checks++; if (hs !== 1'b1) begin errors++; $display("FAIL hs_655: got %b want 1", hs); end
        wait_edge(stage_a(656, 2, 800) + 2);
        checks++; if (hs !== 1'b0) begin errors++; $display("FAIL hs_656: got %b want 0", hs); end
        wait_edge(stage_a(751, 2, 800) + 2);
        checks++; if (hs !== 1'b0) begin errors++; $display("FAIL hs_751: got %b want 0", hs); end
        wait_edge(stage_a(752, 2, 800) + 2);
        checks++; if (hs !== 1'b1) begin errors++; $display("FAIL hs_752: got %b want 1", hs); end
    endtask

    task automatic test_line_timing();
        int hs_lo, bl_hi;
        hs_lo = 0; bl_hi = 0;
        wait_edge(4800);
        for (int i = 0; i < 1600; i++) begin
            if (hs === 1'b0) hs_lo++;
            if (blank_n === 1'b1) bl_hi++;
            @(negedge CLOCK_50);
        end
        checks++; if (hs_lo !== 192)  begin errors++; $display("FAIL line_hs: got %0d want 192", hs_lo); end
        checks++; if (bl_hi !== 1280) begin errors++; $display("FAIL line_blank: got %0d want 1280", bl_hi); end
    endtask

    task automatic test_blanking();
        wait_edge(stage_a(639, 4, 800));
        checks++; if (fb_enable !== 1'b1) begin errors++; $display("FAIL en_639: got %b want 1", fb_enable); end
        wait_edge(stage_a(640, 4, 800));
        checks++; if (fb_enable !== 1'b0) begin errors++; $display("FAIL en_640: got %b want 0", fb_enable); end
        wait_edge(7750);
        force_ff = 1'b1;
        wait_edge(stage_a(700, 4, 800));
        checks++; if (fb_enable !== 1'b0) begin errors++; $display("FAIL en_700: got %b want 0", fb_enable); end
        wait_edge(stage_a(700, 4, 800) + 2);
        checks++; if ({r, g, b} !== 24'h0) begin errors++; $display("FAIL blank_rgb: got %h want 0", {r, g, b}); end
        checks++; if (blank_n !== 1'b0) begin errors++; $display("FAIL blank_n_700: got %b want 0", blank_n); end
        wait_edge(7850);
        force_ff = 1'b0;
    endtask

    task automatic test_mid_reset();
        wait_edge(stage_a(300, 6, 800));
        checks++; if (blank_n !== 1'b1) begin errors++; $display("FAIL pre_rst_blank: got %b want 1", blank_n); end
        rst = 1'b1;
        #1;
        checks++; if (fb_addr !== 20'd0)  begin errors++; $display("FAIL mid_rst_addr: got %h want 0", fb_addr); end
        checks++; if (fb_enable !== 1'b0) begin errors++; $display("FAIL mid_rst_en: got %b want 0", fb_enable); end
        checks++; if (blank_n !== 1'b0)   begin errors++; $display("FAIL mid_rst_blank: got %b want 0", blank_n); end
        checks++; if (r !== 8'h0)         begin errors++; $display("FAIL mid_rst_r: got %h want 0", r); end
        @(negedge CLOCK_50);
        rst = 1'b0;
        wait_edge(3);
        checks++; if (fs !== 1'b0) begin errors++; $display("FAIL mid_fs_e3: got %b want 0", fs); end
        wait_edge(4);
        checks++; if (fs !== 1'b1) begin errors++; $display("FAIL mid_fs_e4: got %b want 1", fs); end
        checks++; if (r !== 8'h5A) begin errors++; $display("FAIL mid_rgb_e4: got %h want 5a", r); end
    endtask

`ifdef TEST_PATTERN_EN
    task automatic test_pattern();
        wait_edge(5);
        test_mode = 1'b1;
        wait_edge(stage_a(40, 0, 800) + 2);
        checks++; if (r !== 8'h00) begin errors++; $display("FAIL tp_h40: got %h want 00", r); end
        wait_edge(stage_a(130, 0, 800));
        checks++; if (fb_enable !== 1'b0) begin errors++; $display("FAIL tp_en: got %b want 0", fb_enable); end
        wait_edge(stage_a(130, 0, 800) + 2);
        checks++; if (r !== 8'h20) begin errors++; $display("FAIL tp_h130: got %h want 20", r); end
        wait_edge(stage_a(300, 0, 800) + 2);
        checks++; if (b !== 8'h40) begin errors++; $display("FAIL tp_h300: got %h want 40", b); end
        test_mode = 1'b0;
    endtask
`endif

    task automatic test_no_write();
        checks++; if (wr_bad !== 0) begin errors++; $display("FAIL fb_write: got %0d strobes want 0", wr_bad); end
    endtask

    initial begin
        checks = 0; errors = 0; wr_bad = 0; force_ff = 1'b0;
`ifdef TEST_PATTERN_EN
        test_mode = 1'b0;
`endif
        test_reset();
        test_first_pixel();
        test_scaling();
        test_small_frame();
        test_hsync_edges();
        test_line_timing();
        test_blanking();
        test_mid_reset();
`ifdef TEST_PATTERN_EN
        test_pattern();
`endif
        test_no_write();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
